blob_pipeline_sequencer: RTL and testbench
==========================================

BLOB_PIPELINE_SEQUENCER -- requirements
Module: blob_pipeline_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of sequenced stages. Index 0 = colour classification, 1 = blob extraction, 2 = blob sorting, 3 = tracking output.
REQ-002 Parameter TIMEOUT_W, default 24: watchdog counter width.
REQ-003 Port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port frame_start, input, 1: one-cycle pulse requesting a new frame pass.
REQ-006 Port pause, input, 1: freezes sequencing.
REQ-007 Port stage_mask, input, NUM_STAGES: bit i=1 runs stage i; bit i=0 skips it. Sampled on frame_start.
REQ-008 Port stage_enable, output, NUM_STAGES: one-hot enable to each stage.
REQ-009 Port stage_done, input, NUM_STAGES: level done from each stage, held while its enable is high.
REQ-010 Port stage_wren / stage_address / stage_data_write, input, NUM_STAGES x 1 / x18 / x32: per-stage memory requests.
REQ-011 Port wren / address / data_write, output, 1 / 18 / 32: shared SRAM port.
REQ-012 Port blob_counter_in, input, 16: blob count from the extraction stage.
REQ-013 Port blob_counter, output, 16: count latched for downstream stages.
REQ-014 Port busy, output, 1; frame_done, output, 1 (one-cycle pulse); timeout_error, output, 1 (sticky).

Function
REQ-015 States: IDLE, RUN, GAP, DONE.
REQ-016 IDLE: on frame_start, latch stage_mask, clear timeout_error, select the lowest set mask bit and go to RUN. If the mask is zero, go directly to DONE.
REQ-017 RUN: assert stage_enable[sel]. When stage_done[sel]=1, deassert the enable on the next edge and go to GAP.
REQ-018 GAP: lasts exactly one cycle with all enables low. Then go to RUN with the next higher set mask bit, or go to DONE if none remains.
REQ-019 DONE: pulse frame_done for one cycle, then return to IDLE.
REQ-020 busy=1 in RUN and GAP.
REQ-021 frame_start outside IDLE is ignored; no queuing.
REQ-022 Memory mux is combinational on the registered select, so granted requests pass with zero latency.
REQ-023 In RUN, wren/address/data_write equal stage_wren[sel]/stage_address[sel]/stage_data_write[sel].
REQ-024 Outside RUN, wren=0, address=0 and data_write=0. Requests from non-selected stages are ignored.
REQ-025 blob_counter latches blob_counter_in on the cycle stage_done[1] is accepted. It holds that value until the next acceptance or reset.
REQ-026 Watchdog clears on entry to RUN and increments each non-paused RUN cycle.
REQ-027 When the watchdog reaches all-ones, set timeout_error and treat the stage as done (proceed to GAP).
REQ-028 pause=1 holds the state, select, watchdog and enables unchanged. The memory mux remains active.
REQ-029 A stage_done arriving while pause=1 is acted on at the first unpaused cycle.
REQ-030 Simultaneous timeout expiry and stage_done: proceed once to GAP and do not set timeout_error.

Reset
REQ-031 reset_n low asynchronously forces: IDLE, select 0, mask 0, watchdog 0, all stage_enable 0, wren 0, address 0, data_write 0, blob_counter 0, busy 0, frame_done 0, timeout_error 0.
REQ-032 Reset mid-frame abandons the pass; no frame_done is issued.
REQ-033 Release takes effect on the first rising clk edge after reset_n goes high.

Structure
REQ-034 A shared package holds the state enumeration, the stage-index constants and the SRAM widths (ADDR_W=18, DATA_W=32).
REQ-035 One sub-module, sram_port_mux: a combinational NUM_STAGES-to-1 mux with idle zeroing.

Verification
REQ-036 Mask 4'b1111 with each stage asserting done 10 cycles after its enable:
- enables go 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000 in order;
- frame_done pulses once;
- busy is high throughout the pass.
REQ-037 Mask 4'b0101: only stages 0 and 2 are enabled. Mask 0: frame_done follows frame_start with no enables asserted.
REQ-038 Stage 2 drives address 200000..200038 with wren=0 and stage 1 drives wren=1 simultaneously: shared port shows only stage 2 traffic during stage 2 RUN, and address=0 during GAP.
REQ-039 Stage 1 done with blob_counter_in=12: blob_counter=12 from the next cycle through stage 3.
REQ-040 Pause held 50 cycles mid-RUN, with done arriving during the pause: the transition occurs the first cycle after pause drops. No timeout with TIMEOUT_W=6 and a 50-cycle pause.
REQ-041 Stage 3 never asserts done with TIMEOUT_W=6:
- timeout_error sets after 63 RUN cycles, then frame_done pulses;
- reset_n pulsed low mid-frame returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/blob_pipeline_sequencer_pkg.sv
// Shared types and constants for the blob pipeline sequencer: FSM states,
// stage indices and shared SRAM port widths.
package blob_pipeline_sequencer_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BLOB_W = 16;

  localparam int unsigned STAGE_COLOUR  = 0;
  localparam int unsigned STAGE_EXTRACT = 1;
  localparam int unsigned STAGE_SORT    = 2;
  localparam int unsigned STAGE_TRACK   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/blob_pipeline_sequencer_sram_port_mux.sv
// Combinational NUM_STAGES-to-1 mux onto the shared SRAM port; drives all
// zeros whenever no stage holds the grant.
module sram_port_mux
  import blob_pipeline_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                                 active,
  input  logic [SEL_W-1:0]                     sel,
  input  logic [NUM_STAGES-1:0]                stage_wren,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0]    stage_address,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0]    stage_data_write,
  output logic                                 wren,
  output logic [ADDR_W-1:0]                    address,
  output logic [DATA_W-1:0]                    data_write
);

  always_comb begin
    wren       = 1'b0;
    address    = '0;
    data_write = '0;
    if (active) begin
      wren       = stage_wren[sel];
      address    = stage_address[sel];
      data_write = stage_data_write[sel];
    end
  end

endmodule

// File: rtl/blob_pipeline_sequencer.sv
// Sequences the colour/extract/sort/track stages one at a time per frame,
// granting the shared SRAM port to the running stage, with a per-stage watchdog.
module blob_pipeline_sequencer
  import blob_pipeline_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned TIMEOUT_W  = 24
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 frame_start,
  input  logic                                 pause,
  input  logic [NUM_STAGES-1:0]                stage_mask,
  output logic [NUM_STAGES-1:0]                stage_enable,
  input  logic [NUM_STAGES-1:0]                stage_done,
  input  logic [NUM_STAGES-1:0]                stage_wren,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0]    stage_address,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0]    stage_data_write,
  output logic                                 wren,
  output logic [ADDR_W-1:0]                    address,
  output logic [DATA_W-1:0]                    data_write,
  input  logic [BLOB_W-1:0]                    blob_counter_in,
  output logic [BLOB_W-1:0]                    blob_counter,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 timeout_error
);

  localparam int unsigned SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  // Last value before all-ones: the edge that would reach all-ones is the timeout.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  seq_state_t             state;
  logic [SEL_W-1:0]       sel;
  logic [NUM_STAGES-1:0]  mask;
  logic [TIMEOUT_W-1:0]   wdog;
  logic                   idle_hit;
  logic [SEL_W-1:0]       idle_idx;
  logic                   gap_hit;
  logic [SEL_W-1:0]       gap_idx;

  function automatic logic [SEL_W:0] find_next(input logic [NUM_STAGES-1:0] m,
                                               input int unsigned from);
    logic             hit;
    logic [SEL_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!hit && i >= from && m[i]) begin
        hit = 1'b1;
        idx = SEL_W'(i);
      end
    end
    return {hit, idx};
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_STAGES'(1) << i;
  endfunction

  always_comb begin
    {idle_hit, idle_idx} = find_next(stage_mask, 0);
    {gap_hit, gap_idx}   = find_next(mask, 32'(sel) + 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      sel           <= '0;
      mask          <= '0;
      wdog          <= '0;
      stage_enable  <= '0;
      blob_counter  <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (frame_start) begin
            mask          <= stage_mask;
            timeout_error <= 1'b0;
            if (idle_hit) begin
              sel          <= idle_idx;
              stage_enable <= onehot(idle_idx);
              wdog         <= '0;
              busy         <= 1'b1;
              state        <= ST_RUN;
            end else begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          // done wins over a coincident watchdog expiry
          if (!pause) begin
            if (stage_done[sel]) begin
              stage_enable <= '0;
              state        <= ST_GAP;
              if (32'(sel) == STAGE_EXTRACT) blob_counter <= blob_counter_in;
            end else if (wdog == WDOG_LAST) begin
              timeout_error <= 1'b1;
              stage_enable  <= '0;
              state         <= ST_GAP;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (!pause) begin
            if (gap_hit) begin
              sel          <= gap_idx;
              stage_enable <= onehot(gap_idx);
              wdog         <= '0;
              state        <= ST_RUN;
            end else begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sram_port_mux #(
    .NUM_STAGES (NUM_STAGES),
    .SEL_W      (SEL_W)
  ) u_sram_port_mux (
    .active           (state == ST_RUN),
    .sel              (sel),
    .stage_wren       (stage_wren),
    .stage_address    (stage_address),
    .stage_data_write (stage_data_write),
    .wren             (wren),
    .address          (address),
    .data_write       (data_write)
  );

endmodule

// File: tb/tb_blob_pipeline_sequencer.sv
// Directed bench for blob_pipeline_sequencer: stage responders driven from the
// bench, each scenario task checks its own recorded trace against hand values.
module tb_blob_pipeline_sequencer;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              frame_start = 1'b0;
  logic              pause = 1'b0;
  logic [3:0]        stage_mask = '0;
  logic [3:0]        stage_enable;
  logic [3:0]        stage_done = '0;
  logic [3:0]        stage_wren;
  logic [3:0][17:0]  stage_address;
  logic [3:0][31:0]  stage_data_write;
  logic              wren;
  logic [17:0]       address;
  logic [31:0]       data_write;
  logic [15:0]       blob_counter_in = '0;
  logic [15:0]       blob_counter;
  logic              busy, frame_done, timeout_error;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  en;
    logic        busy;
    logic        fd;
    logic        terr;
    logic        wren;
    logic [17:0] addr;
    logic [31:0] data;
    logic [15:0] bc;
    logic        pz;
    logic [17:0] s2_addr;
    logic [31:0] s2_data;
  } sample_t;

  sample_t    tr[$];
  logic [3:0] seq[$];
  int         fd_count;
  int         done_after[4];
  int         en_cnt[4];
  logic [15:0] blob_val = '0;
  int         pause_stage = -1;
  int         pause_at = 0;
  int         pause_left = 0;

  blob_pipeline_sequencer #(
    .NUM_STAGES (4),
    .TIMEOUT_W  (6)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .frame_start      (frame_start),
    .pause            (pause),
    .stage_mask       (stage_mask),
    .stage_enable     (stage_enable),
    .stage_done       (stage_done),
    .stage_wren       (stage_wren),
    .stage_address    (stage_address),
    .stage_data_write (stage_data_write),
    .wren             (wren),
    .address          (address),
    .data_write       (data_write),
    .blob_counter_in  (blob_counter_in),
    .blob_counter     (blob_counter),
    .busy             (busy),
    .frame_done       (frame_done),
    .timeout_error    (timeout_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation still running, required finish");
    $fatal(1);
  end

  // Stage responders: done after done_after[i] enabled cycles (0 = never).
  task automatic drive_stages();
    for (int i = 0; i < 4; i++) begin
      if (stage_enable[i]) en_cnt[i]++;
      else en_cnt[i] = 0;
      stage_done[i] = (done_after[i] != 0) && (en_cnt[i] >= done_after[i]);
    end
    stage_address[2]    = stage_enable[2] ? 18'(200000 + 2 * en_cnt[2]) : 18'd200000;
    stage_data_write[2] = 32'h A5A5_0000 + 32'(en_cnt[2]);
    blob_counter_in     = stage_enable[1] ? blob_val : 16'hBEEF;
    if (pause_left > 0) begin
      pause = 1'b1;
      pause_left--;
    end else if (pause_stage >= 0 && stage_enable[pause_stage] && en_cnt[pause_stage] == pause_at) begin
      pause = 1'b1;
      pause_left = 49;
      pause_stage = -1;
    end else begin
      pause = 1'b0;
    end
  endtask

  task automatic run_pass(input logic [3:0] mask, input int max_cycles);
    sample_t    s;
    logic [3:0] prev;
    int         tail;
    tr.delete();
    seq.delete();
    fd_count = 0;
    tail = -1;
    prev = stage_enable;
    stage_mask = mask;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int c = 0; c < max_cycles && tail != 0; c++) begin
      s.en = stage_enable;   s.busy = busy;        s.fd = frame_done;
      s.terr = timeout_error; s.wren = wren;       s.addr = address;
      s.data = data_write;   s.bc = blob_counter;
      s.s2_addr = stage_address[2];
      s.s2_data = stage_data_write[2];
      if (stage_enable !== prev) begin
        seq.push_back(stage_enable);
        prev = stage_enable;
      end
      if (frame_done === 1'b1) begin
        fd_count++;
        if (tail < 0) tail = 4;
      end
      drive_stages();
      s.pz = pause;
      tr.push_back(s);
      if (tail > 0) tail--;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({stage_enable, busy, frame_done, timeout_error, wren, address, data_write, blob_counter} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%b busy=%b fd=%b terr=%b wren=%b addr=%h data=%h bc=%h, required all zero",
               stage_enable, busy, frame_done, timeout_error, wren, address, data_write, blob_counter);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({stage_enable, busy, frame_done, wren, address, data_write} !== '0) begin
      failures++;
      $display("FAIL post_release_idle: got en=%b busy=%b fd=%b wren=%b addr=%h, required all zero",
               stage_enable, busy, frame_done, wren, address);
    end
  endtask

  task automatic test_full_pass();
    logic [31:0] got;
    int first_en, fd_idx, busy_bad;
    for (int i = 0; i < 4; i++) done_after[i] = 10;
    run_pass(4'b1111, 300);
    got = '0;
    foreach (seq[i]) got = {got[27:0], seq[i]};
    checks++;
    if (seq.size() != 8 || got !== 32'h1020_4080) begin
      failures++;
      $display("FAIL full_enable_seq: got %0d entries %h, required 8 entries 10204080", seq.size(), got);
    end
    checks++;
    if (fd_count != 1) begin
      failures++;
      $display("FAIL full_frame_done_count: got %0d, required 1", fd_count);
    end
    first_en = -1; fd_idx = -1; busy_bad = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (first_en < 0 && tr[i].en != 0) first_en = i;
      if (fd_idx < 0 && tr[i].fd === 1'b1) fd_idx = i;
      if (first_en >= 0 && fd_idx < 0 && tr[i].busy !== 1'b1) busy_bad++;
    end
    checks++;
    if (first_en != 0 || busy_bad != 0) begin
      failures++;
      $display("FAIL full_busy: got first_en=%0d busy_low=%0d, required 0 and 0", first_en, busy_bad);
    end
    checks++;
    if (fd_idx != 44) begin
      failures++;
      $display("FAIL full_frame_done_time: got cycle %0d, required 44", fd_idx);
    end
    checks++;
    if (fd_idx < 0 || tr[fd_idx].busy !== 1'b0) begin
      failures++;
      $display("FAIL full_busy_at_done: busy still high or no frame_done (idx %0d), required busy=0", fd_idx);
    end
  endtask

  task automatic test_sparse_mask();
    logic [15:0] got;
    run_pass(4'b0101, 200);
    got = '0;
    foreach (seq[i]) got = {got[11:0], seq[i]};
    checks++;
    if (seq.size() != 4 || got !== 16'h1040 || fd_count != 1) begin
      failures++;
      $display("FAIL sparse_enable_seq: got %0d entries %h fd=%0d, required 4 entries 1040 fd=1",
               seq.size(), got, fd_count);
    end
  endtask

  task automatic test_zero_mask();
    run_pass(4'b0000, 20);
    checks++;
    if (seq.size() != 0 || fd_count != 1) begin
      failures++;
      $display("FAIL zero_mask: got %0d enable changes fd=%0d, required 0 and 1", seq.size(), fd_count);
    end
    checks++;
    if (tr.size() == 0 || tr[0].fd !== 1'b1 || tr[0].busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_mask_latency: frame_done not on first cycle after frame_start or busy high");
    end
  endtask

  task automatic test_mux();
    int n_s2, first_s2, last_s2, bad_s2, bad_s1, bad_idle;
    done_after[1] = 5;
    done_after[2] = 20;
    run_pass(4'b0110, 200);
    n_s2 = 0; first_s2 = -1; last_s2 = -1; bad_s2 = 0; bad_s1 = 0; bad_idle = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i].en == 4'b0100) begin
        n_s2++;
        if (first_s2 < 0) first_s2 = i;
        last_s2 = i;
        if (tr[i].wren !== 1'b0 || tr[i].addr !== tr[i].s2_addr || tr[i].data !== tr[i].s2_data) bad_s2++;
      end else if (tr[i].en == 4'b0010) begin
        if (tr[i].wren !== 1'b1 || tr[i].addr !== 18'h3FFFF || tr[i].data !== 32'hDEADBEEF) bad_s1++;
      end else if (tr[i].en == 4'b0000) begin
        if (tr[i].wren !== 1'b0 || tr[i].addr !== 18'd0 || tr[i].data !== 32'd0) bad_idle++;
      end
    end
    checks++;
    if (n_s2 != 20 || bad_s2 != 0) begin
      failures++;
      $display("FAIL mux_stage2: got %0d cycles %0d bad, required 20 cycles 0 bad", n_s2, bad_s2);
    end
    checks++;
    if (first_s2 < 0 || tr[first_s2].addr !== 18'd200000 || tr[last_s2].addr !== 18'd200038) begin
      failures++;
      $display("FAIL mux_stage2_range: first/last stage-2 address wrong, required 200000..200038");
    end
    checks++;
    if (bad_s1 != 0) begin
      failures++;
      $display("FAIL mux_stage1: got %0d bad cycles, required 0", bad_s1);
    end
    checks++;
    if (bad_idle != 0) begin
      failures++;
      $display("FAIL mux_idle_zero: got %0d nonzero cycles, required 0", bad_idle);
    end
  endtask

  task automatic test_blob();
    int last_s1, bad_pre, bad_post;
    blob_val = 16'd12;
    done_after[1] = 10;
    done_after[3] = 10;
    run_pass(4'b1010, 200);
    last_s1 = -1; bad_pre = 0; bad_post = 0;
    for (int i = 0; i < tr.size(); i++)
      if (tr[i].en == 4'b0010) last_s1 = i;
    for (int i = 0; i < tr.size(); i++) begin
      if (i <= last_s1 && tr[i].bc !== 16'd0) bad_pre++;
      if (i > last_s1 && tr[i].bc !== 16'd12) bad_post++;
    end
    checks++;
    if (last_s1 != 9 || bad_pre != 0) begin
      failures++;
      $display("FAIL blob_before_done: last stage-1 cycle %0d, %0d bad, required 9 and 0", last_s1, bad_pre);
    end
    checks++;
    if (bad_post != 0 || fd_count != 1) begin
      failures++;
      $display("FAIL blob_latched: got %0d cycles not 12 fd=%0d, required 0 and 1", bad_post, fd_count);
    end
  endtask

  task automatic test_pause();
    int n_en, j, bad_terr, bad_s2;
    done_after[2] = 20;
    pause_stage = 2;
    pause_at = 15;
    run_pass(4'b0100, 300);
    n_en = 0; j = -1; bad_terr = 0; bad_s2 = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i].en == 4'b0100) begin
        n_en++;
        if (tr[i].addr !== tr[i].s2_addr) bad_s2++;
      end else if (j < 0 && n_en > 0) j = i;
      if (tr[i].terr !== 1'b0) bad_terr++;
    end
    checks++;
    if (n_en != 65 || j != 65) begin
      failures++;
      $display("FAIL pause_hold: got %0d enabled cycles drop at %0d, required 65 and 65", n_en, j);
    end
    checks++;
    if (j < 2 || tr[j-1].pz !== 1'b0 || tr[j-2].pz !== 1'b1) begin
      failures++;
      $display("FAIL pause_release_edge: transition not on first unpaused cycle (drop at %0d)", j);
    end
    checks++;
    if (bad_terr != 0 || bad_s2 != 0 || fd_count != 1) begin
      failures++;
      $display("FAIL pause_side_effects: got terr=%0d mux_bad=%0d fd=%0d, required 0 0 1",
               bad_terr, bad_s2, fd_count);
    end
  endtask

  task automatic test_timeout();
    int n_en, bad_terr, fd_idx;
    done_after[3] = 0;
    run_pass(4'b1000, 200);
    n_en = 0; bad_terr = 0; fd_idx = -1;
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i].en == 4'b1000) begin
        n_en++;
        if (tr[i].terr !== 1'b0) bad_terr++;
      end
      if (fd_idx < 0 && tr[i].fd === 1'b1) fd_idx = i;
    end
    checks++;
    if (n_en != 63 || bad_terr != 0) begin
      failures++;
      $display("FAIL timeout_run_cycles: got %0d cycles early_terr=%0d, required 63 and 0", n_en, bad_terr);
    end
    checks++;
    if (tr.size() < 65 || tr[63].en !== 4'b0000 || tr[63].terr !== 1'b1 || tr[64].terr !== 1'b1) begin
      failures++;
      $display("FAIL timeout_error_set: timeout_error not set at cycle 63 with enables low");
    end
    checks++;
    if (fd_idx != 64 || fd_count != 1) begin
      failures++;
      $display("FAIL timeout_frame_done: got idx %0d count %0d, required 64 and 1", fd_idx, fd_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    checks++;
    if (timeout_error !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: got %b, required 1", timeout_error);
    end
    done_after[1] = 0;
    stage_mask = 4'b0010;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_stages();
      @(negedge clk);
    end
    checks++;
    if (stage_enable !== 4'b0010 || wren !== 1'b1 || address !== 18'h3FFFF || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_frame_pre: got en=%b wren=%b addr=%h busy=%b, required 0010 1 3ffff 1",
               stage_enable, wren, address, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({stage_enable, busy, frame_done, timeout_error, wren, address, data_write, blob_counter} !== '0) begin
      failures++;
      $display("FAIL mid_frame_reset: got en=%b busy=%b fd=%b terr=%b wren=%b addr=%h data=%h bc=%h, required all zero",
               stage_enable, busy, frame_done, timeout_error, wren, address, data_write, blob_counter);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || stage_enable !== 4'b0000 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abandoned_frame: got %0d cycles with activity, required 0", bad);
    end
    done_after[0] = 3;
    run_pass(4'b0001, 50);
    checks++;
    if (fd_count != 1 || seq.size() != 2) begin
      failures++;
      $display("FAIL recovery_pass: got fd=%0d changes=%0d, required 1 and 2", fd_count, seq.size());
    end
  endtask

  initial begin
    stage_wren          = 4'b1011;
    stage_address[0]    = 18'h00123;
    stage_address[1]    = 18'h3FFFF;
    stage_address[2]    = 18'd200000;
    stage_address[3]    = 18'h2AAAA;
    stage_data_write[0] = 32'h0C0C_0C0C;
    stage_data_write[1] = 32'hDEAD_BEEF;
    stage_data_write[2] = 32'hA5A5_0000;
    stage_data_write[3] = 32'h3333_3333;
    for (int i = 0; i < 4; i++) begin
      done_after[i] = 10;
      en_cnt[i] = 0;
    end
    test_reset();
    test_full_pass();
    test_sparse_mask();
    test_zero_mask();
    test_mux();
    test_blob();
    test_pause();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
